// File: rtl/grid_trace_tracker.sv
// Per-player trace grid: latches IR hits into a GRID_N x GRID_N trace map and colours the current VGA pixel.
// Optional snitch blinking is enabled with the SNITCH_BLINK_EN macro.
module grid_trace_tracker #(
  parameter int GRID_N       = 4,
  parameter int X0           = 120,
  parameter int Y0           = 40,
  parameter int BOX_W        = 100,
  parameter int BOX_H        = 100,
  parameter int HOLD_CYCLES  = 10000000,
  parameter int BROOM_CELL   = 6,
  parameter int BLINK_CYCLES = 12500000,
  localparam int NC          = GRID_N * GRID_N,
  localparam int CW          = $clog2(NC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    row,
  input  logic [9:0]    col,
  input  logic [NC-1:0] ir_in,
  input  logic [3:0]    house,
  input  logic          broom_powerup,
  input  logic          two_player_mode,
  input  logic          clear_my_trace,
  input  logic          reset_trace,
  input  logic [NC-1:0] snitch_location,
  input  logic [NC-1:0] displayed_trace,
  output logic [NC-1:0] already_traced,
  output logic          color_in_box,
  output logic [7:0]    box_color,
  output logic          reset_other_player_trace,
  output logic          trace_complete,
  output logic [CW-1:0] hit_count,
  output logic [CW-1:0] miss_count
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [HW-1:0]     hold_cnt;
  logic              hold_idle;
  logic              broom_clear;
  logic              complete_now;
  logic              complete_q;
  logic [GRID_N-1:0] row_hit;
  logic [GRID_N-1:0] col_hit;
  logic [NC-1:0]     cell_mask;
  logic [31:0]       row_w;
  logic [31:0]       col_w;
  logic              in_cell;
  logic              traced_at;
  logic              snitch_at;
  logic              target_at;
  logic              pix_lit;
  logic              snitch_pix;
  logic [7:0]        snitch_color;
  logic [7:0]        color_d;

  function automatic logic [CW-1:0] popcount(input logic [NC-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NC; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign hold_idle   = (hold_cnt == '0);
  assign broom_clear = (~two_player_mode & broom_powerup & ir_in[BROOM_CELL]) |
                       (two_player_mode & clear_my_trace);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (reset_trace) begin
      hold_cnt <= HW'(HOLD_CYCLES);
    end else if (!hold_idle) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // Clear sources outrank the latch; the latch itself is not pixel-gated.
  always_ff @(posedge clk) begin
    if (reset) begin
      already_traced <= '0;
    end else if (!hold_idle) begin
      already_traced <= '0;
    end else if (broom_clear) begin
      already_traced <= '0;
    end else begin
      already_traced <= already_traced | ir_in;
    end
  end

  // One comparator pair per grid row and per grid column; a cell is their AND.
  assign row_w = 32'(row);
  assign col_w = 32'(col);

  for (genvar r = 0; r < GRID_N; r++) begin : g_row
    assign row_hit[r] = (row_w >= 32'(Y0 + r * BOX_H)) && (row_w < 32'(Y0 + (r + 1) * BOX_H));
  end

  for (genvar c = 0; c < GRID_N; c++) begin : g_col
    assign col_hit[c] = (col_w >= 32'(X0 + c * BOX_W)) && (col_w < 32'(X0 + (c + 1) * BOX_W));
  end

  for (genvar i = 0; i < NC; i++) begin : g_cell
    assign cell_mask[i] = row_hit[i / GRID_N] & col_hit[i % GRID_N];
  end

  assign in_cell   = |cell_mask;
  assign traced_at = |(cell_mask & already_traced);
  assign snitch_at = |(cell_mask & already_traced & snitch_location);
  assign target_at = |(cell_mask & displayed_trace);

`ifdef SNITCH_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign snitch_color = blink ? 8'h50 : 8'h00;
`else
  assign snitch_color = 8'h50;
`endif

  always_comb begin
    pix_lit    = in_cell & traced_at & hold_idle;
    snitch_pix = in_cell & snitch_at;
    color_d    = 8'h00;
    if (snitch_pix) begin
      color_d = snitch_color;
    end else if (!pix_lit || house == 4'b0000) begin
      color_d = 8'h00;
    end else if (house[3]) begin
      color_d = target_at ? 8'h9A : 8'h99;
    end else if (house[2]) begin
      color_d = target_at ? 8'h16 : 8'h17;
    end else if (house[1]) begin
      color_d = target_at ? 8'h49 : 8'h50;
    end else begin
      color_d = target_at ? 8'hDC : 8'hDD;
    end
  end

  assign complete_now = (displayed_trace != '0) &&
                        ((already_traced & displayed_trace) == displayed_trace) && hold_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      color_in_box             <= 1'b0;
      box_color                <= 8'h00;
      reset_other_player_trace <= 1'b0;
      trace_complete           <= 1'b0;
      complete_q               <= 1'b0;
      hit_count                <= '0;
      miss_count               <= '0;
    end else begin
      color_in_box             <= pix_lit;
      box_color                <= color_d;
      reset_other_player_trace <= two_player_mode & broom_powerup & ir_in[BROOM_CELL];
      trace_complete           <= complete_now & ~complete_q;
      complete_q               <= complete_now;
      hit_count                <= popcount(already_traced & displayed_trace);
      miss_count               <= popcount(already_traced & ~displayed_trace);
    end
  end

endmodule

// File: tb/tb_grid_trace_tracker.sv
// Directed bench for grid_trace_tracker: expectations queued at drive time, popped and asserted after the clock.
module tb_grid_trace_tracker;

  localparam int NC = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    row;
  logic [9:0]    col;
  logic [NC-1:0] ir_in;
  logic [3:0]    house;
  logic          broom_powerup;
  logic          two_player_mode;
  logic          clear_my_trace;
  logic          reset_trace;
  logic [NC-1:0] snitch_location;
  logic [NC-1:0] displayed_trace;
  logic [NC-1:0] already_traced;
  logic          color_in_box;
  logic [7:0]    box_color;
  logic          reset_other_player_trace;
  logic          trace_complete;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks   = 0;
  int          failures = 0;

  grid_trace_tracker #(
    .HOLD_CYCLES (8),
    .BLINK_CYCLES(4)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .row                     (row),
    .col                     (col),
    .ir_in                   (ir_in),
    .house                   (house),
    .broom_powerup           (broom_powerup),
    .two_player_mode         (two_player_mode),
    .clear_my_trace          (clear_my_trace),
    .reset_trace             (reset_trace),
    .snitch_location         (snitch_location),
    .displayed_trace         (displayed_trace),
    .already_traced          (already_traced),
    .color_in_box            (color_in_box),
    .box_color               (box_color),
    .reset_other_player_trace(reset_other_player_trace),
    .trace_complete          (trace_complete),
    .hit_count               (hit_count),
    .miss_count              (miss_count)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  // Scoreboard
  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
      end
    end
  endtask

  task automatic color_case(input string t, input logic [8:0] r, input logic [9:0] c,
                            input logic [3:0] h, input logic d5,
                            input logic cib_e, input logic [7:0] col_e);
    row             = r;
    col             = c;
    house           = h;
    displayed_trace = NC'(d5) << 5;
    push({t, "_cib"}, 32'(cib_e));
    push({t, "_color"}, 32'(col_e));
    tick();
    pop_check(32'(color_in_box));
    pop_check(32'(box_color));
  endtask

  initial begin
    reset           = 1'b1;
    row             = '0;
    col             = '0;
    ir_in           = '1;
    house           = 4'b0000;
    broom_powerup   = 1'b0;
    two_player_mode = 1'b0;
    clear_my_trace  = 1'b0;
    reset_trace     = 1'b0;
    snitch_location = '0;
    displayed_trace = '0;

    // Reset with every sensor firing
    push("rst_traced", 32'h0);
    push("rst_color", 32'h0);
    push("rst_cib", 32'h0);
    push("rst_hits", 32'h0);
    push("rst_misses", 32'h0);
    push("rst_complete", 32'h0);
    push("rst_other", 32'h0);
    tick();
    pop_check(32'(already_traced));
    pop_check(32'(box_color));
    pop_check(32'(color_in_box));
    pop_check(32'(hit_count));
    pop_check(32'(miss_count));
    pop_check(32'(trace_complete));
    pop_check(32'(reset_other_player_trace));
    reset = 1'b0;
    ir_in = '0;
    tick();

    // Cell 5 hit, house S, pixel inside cell 5
    house           = 4'b0100;
    displayed_trace = NC'(1) << 5;
    row             = 9'd150;
    col             = 10'd250;
    ir_in           = NC'(1) << 5;
    push("latch5", 32'h0020);
    tick();
    pop_check(32'(already_traced));
    ir_in = '0;
    push("s_hit_cib", 32'h1);
    push("s_hit_color", 32'h16);
    push("s_hit_count", 32'h1);
    tick();
    pop_check(32'(color_in_box));
    pop_check(32'(box_color));
    pop_check(32'(hit_count));
    displayed_trace = '0;
    push("s_miss_color", 32'h17);
    push("s_miss_count", 32'h1);
    push("s_miss_hits", 32'h0);
    tick();
    pop_check(32'(box_color));
    pop_check(32'(miss_count));
    pop_check(32'(hit_count));

    // House palette, priority and cell boundaries
    color_case("r_hit",   9'd150, 10'd250, 4'b1000, 1'b1, 1'b1, 8'h9A);
    color_case("r_miss",  9'd150, 10'd250, 4'b1000, 1'b0, 1'b1, 8'h99);
    color_case("g_hit",   9'd150, 10'd250, 4'b0010, 1'b1, 1'b1, 8'h49);
    color_case("g_miss",  9'd150, 10'd250, 4'b0010, 1'b0, 1'b1, 8'h50);
    color_case("h_hit",   9'd150, 10'd250, 4'b0001, 1'b1, 1'b1, 8'hDC);
    color_case("h_miss",  9'd150, 10'd250, 4'b0001, 1'b0, 1'b1, 8'hDD);
    color_case("all_hse", 9'd150, 10'd250, 4'b1111, 1'b1, 1'b1, 8'h9A);
    color_case("no_hse",  9'd150, 10'd250, 4'b0000, 1'b1, 1'b1, 8'h00);
    color_case("tl_edge", 9'd140, 10'd220, 4'b0100, 1'b1, 1'b1, 8'h16);
    color_case("above",   9'd139, 10'd220, 4'b0100, 1'b1, 1'b0, 8'h00);
    color_case("left",    9'd150, 10'd219, 4'b0100, 1'b1, 1'b0, 8'h00);
    color_case("br_edge", 9'd239, 10'd319, 4'b0100, 1'b1, 1'b1, 8'h16);
    color_case("outside", 9'd10,  10'd250, 4'b0100, 1'b1, 1'b0, 8'h00);
    color_case("off_x",   9'd150, 10'd100, 4'b0100, 1'b1, 1'b0, 8'h00);
    displayed_trace = '0;

    // Clear-hold: the loading edge still latches, then 8 cleared cycles
    ir_in       = NC'(1);
    reset_trace = 1'b1;
    push("hold_load", 32'h0021);
    tick();
    pop_check(32'(already_traced));
    reset_trace = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push($sformatf("hold_c%0d", k), 32'h0);
      tick();
      pop_check(32'(already_traced));
    end
    push("hold_end", 32'h0001);
    tick();
    pop_check(32'(already_traced));

    // Retriggered hold: second reset_trace at cycle 4 stretches it to cycle 12
    reset_trace = 1'b1;
    push("rehold_load", 32'h0001);
    tick();
    pop_check(32'(already_traced));
    reset_trace = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      reset_trace = (k == 4);
      push($sformatf("rehold_c%0d", k), 32'h0);
      tick();
      pop_check(32'(already_traced));
    end
    reset_trace = 1'b0;
    push("rehold_end", 32'h0001);
    tick();
    pop_check(32'(already_traced));

    // Broom in single-player clears locally
    broom_powerup = 1'b1;
    ir_in         = NC'(1) << 6;
    push("broom1_traced", 32'h0);
    push("broom1_other", 32'h0);
    tick();
    pop_check(32'(already_traced));
    pop_check(32'(reset_other_player_trace));

    // Broom in two-player mode targets the opponent instead
    two_player_mode = 1'b1;
    push("broom2_traced", 32'h0040);
    push("broom2_other", 32'h1);
    tick();
    pop_check(32'(already_traced));
    pop_check(32'(reset_other_player_trace));
    ir_in = '0;
    push("broom2_other_end", 32'h0);
    tick();
    pop_check(32'(reset_other_player_trace));
    clear_my_trace = 1'b1;
    push("opp_clear", 32'h0);
    tick();
    pop_check(32'(already_traced));
    clear_my_trace  = 1'b0;
    two_player_mode = 1'b0;
    broom_powerup   = 1'b0;

    // Trace completion pulse on a two-cell target
    displayed_trace = NC'(3);
    ir_in           = NC'(1);
    push("tc_cell0", 32'h0);
    tick();
    pop_check(32'(trace_complete));
    ir_in = NC'(2);
    push("tc_cell1", 32'h0);
    tick();
    pop_check(32'(trace_complete));
    push("tc_pulse", 32'h1);
    push("tc_hits", 32'h2);
    tick();
    pop_check(32'(trace_complete));
    pop_check(32'(hit_count));
    for (int k = 0; k < 3; k++) begin
      push($sformatf("tc_quiet%0d", k), 32'h0);
      tick();
      pop_check(32'(trace_complete));
    end
    ir_in = '0;

    // Snitch on traced cell 15
    snitch_location = NC'(1) << 15;
    house           = 4'b0000;
    row             = 9'd400;
    col             = 10'd450;
    ir_in           = NC'(1) << 15;
    push("snitch_latch", 32'h8003);
    tick();
    pop_check(32'(already_traced));
    ir_in = '0;
    push("snitch_cib", 32'h1);
    tick();
    pop_check(32'(color_in_box));
`ifndef SNITCH_BLINK_EN
    push("snitch_color", 32'h50);
    pop_check(32'(box_color));
`endif

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
